// File: rtl/addition_result_reader_if.sv
// Bundle of the drain-control, buffer-read and result-stream signals of addition_result_reader.
// The master modport is the reader itself; the slave modport is its environment.
interface addition_result_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1024
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              start;
    logic [IDX_W-1:0]  base_addr;
    logic [IDX_W:0]    length;

    logic              mem_CEN;
    logic              mem_WEN;
    logic              mem_RETN;
    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_Q;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, length, mem_Q, out_ready,
        output mem_CEN, mem_WEN, mem_RETN, mem_A,
        output out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, base_addr, length, mem_Q, out_ready,
        input  mem_CEN, mem_WEN, mem_RETN, mem_A,
        input  out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/addition_result_reader.sv
// Drains a window of a single-port result buffer (wrapping at DEPTH) into a
// ready/valid stream through a 2-entry fall-through FIFO.
module addition_result_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    addition_result_reader_if.master bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  rd_addr_reg;
    logic [IDX_W:0]    rd_left_reg;
    logic [IDX_W:0]    len_reg;
    logic [IDX_W:0]    out_cnt_reg;
    logic              inflight_reg;
    logic [1:0]        count_reg;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic              done_reg;
    logic [DATA_W-1:0] fifo_mem [2];

    logic              issue;
    logic              pop;
    logic              push;
    logic              head_pop;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_data;

    // Occupancy counts both stored words and the word still on its way back
    // from the buffer, so a returning word always has a slot.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && bus.length != '0)
                    state_next = RUN;
            end
            RUN: begin
                issue = ({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2;
                if (issue && rd_left_reg == (IDX_W+1)'(1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // With the FIFO empty the word arriving on mem_Q is presented directly,
    // which gives the two-cycle start-to-valid latency and full throughput.
    assign out_valid = (count_reg != 2'd0) || inflight_reg;
    assign out_data  = (count_reg != 2'd0) ? fifo_mem[rd_ptr_reg] :
                       (inflight_reg ? bus.mem_Q : '0);
    assign out_last  = out_valid && (out_cnt_reg == len_reg - (IDX_W+1)'(1));
    assign pop       = out_valid && bus.out_ready;
    assign head_pop  = pop && (count_reg != 2'd0);
    assign push      = inflight_reg && !((count_reg == 2'd0) && pop);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_addr_reg  <= '0;
            rd_left_reg  <= '0;
            len_reg      <= '0;
            out_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= ((state_reg == DRAIN) && pop && out_last) ||
                        ((state_reg == IDLE) && bus.start && bus.length == '0);

            if (state_reg == IDLE && bus.start) begin
                rd_addr_reg <= bus.base_addr;
                rd_left_reg <= bus.length;
                len_reg     <= bus.length;
                out_cnt_reg <= '0;
            end else begin
                if (issue) begin
                    rd_addr_reg <= rd_addr_reg + IDX_W'(1);
                    rd_left_reg <= rd_left_reg - (IDX_W+1)'(1);
                end
                if (pop)
                    out_cnt_reg <= out_cnt_reg + (IDX_W+1)'(1);
            end

            inflight_reg <= issue;

            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (head_pop)
                rd_ptr_reg <= ~rd_ptr_reg;

            case ({push, head_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge CLK) begin
                if (push && wr_ptr_reg == 1'(gi))
                    fifo_mem[gi] <= bus.mem_Q;
            end
        end
    endgenerate

    assign bus.mem_CEN   = !issue;
    assign bus.mem_WEN   = 1'b1;
    assign bus.mem_RETN  = 1'b1;
    assign bus.mem_A     = issue ? ADDR_W'(rd_addr_reg) : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_addition_result_reader.sv
// Randomised scoreboard bench for addition_result_reader: a transfer-level model
// queues expected words and addresses; a negedge monitor compares every cycle.
module tb_addition_result_reader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1024;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    addition_result_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    addition_result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    exp_t exp_q[$];
    int   addr_q[$];

    bit          active_m = 1'b0;
    int          outstanding = 0;
    bit          done_exp = 1'b0;
    bit          post_rst = 1'b0;
    bit          prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic        prev_last;
    bit          lat_armed = 1'b0;
    int          lat_cnt = 0;
    int          acc_cnt = 0;
    int          ready_mode = 0;
    int          pat_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        bus.start     = 1'b1;
        bus.base_addr = 10'(b);
        bus.length    = 11'(l);
        $display("[TB] start base=%0d length=%0d ready_mode=%0d", b, l, ready_mode);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (active_m && n < budget) begin
            tick();
            n++;
        end
        if (active_m) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: transfer still active after %0d cycles", budget);
        end
        tick();
        tick();
    endtask

    // Behavioural buffer: one-cycle read latency, drives 0 when not enabled.
    initial begin
        logic              c;
        logic [ADDR_W-1:0] a;
        bus.mem_Q = '0;
        forever begin
            @(negedge CLK);
            c = bus.mem_CEN;
            a = bus.mem_A;
            @(posedge CLK);
            #1;
            bus.mem_Q = !c ? mem[a[9:0]] : '0;
        end
    end

    // Sink back-pressure: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                    pat_idx++;
                end
                default: bus.out_ready = ($urandom_range(0, 99) < 65);
            endcase
        end
    end

    // Monitor and reference model, evaluated once per cycle away from the edge.
    initial begin
        exp_t e;
        bit   accepted, last_acc, done_next, active_cur;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                exp_q.delete();
                addr_q.delete();
                active_m    = 1'b0;
                outstanding = 0;
                done_exp    = 1'b0;
                post_rst    = 1'b1;
                prev_stall  = 1'b0;
                lat_armed   = 1'b0;
            end else begin
                if (post_rst) begin
                    chk("rst_out_valid", bus.out_valid, 1'b0);
                    chk("rst_mem_cen",   bus.mem_CEN,   1'b1);
                    chk("rst_mem_a",     bus.mem_A,     '0);
                    chk("rst_out_data",  bus.out_data,  '0);
                    chk("rst_out_last",  bus.out_last,  1'b0);
                    chk("rst_mem_wen",   bus.mem_WEN,   1'b1);
                    chk("rst_mem_retn",  bus.mem_RETN,  1'b1);
                    post_rst = 1'b0;
                end
                chk("busy", bus.busy, active_m);
                chk("done", bus.done, done_exp);

                if (lat_armed) begin
                    lat_cnt++;
                    if (bus.out_valid || lat_cnt > 2) begin
                        chk("first_valid_latency", 64'(lat_cnt), 64'd2);
                        lat_armed = 1'b0;
                    end
                end

                if (prev_stall) begin
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk("stall_data",  bus.out_data,  prev_data);
                    chk("stall_last",  bus.out_last,  prev_last);
                end

                if (!bus.mem_CEN) begin
                    if (!active_m || addr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_read: mem_A=%0d with no read pending", bus.mem_A);
                    end else begin
                        chk("mem_A", bus.mem_A, 64'(addr_q.pop_front()));
                        chk("read_budget", (outstanding < 2), 1'b1);
                    end
                end

                accepted = bus.out_valid && bus.out_ready;
                last_acc = 1'b0;
                if (accepted) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h with nothing expected", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        chk("out_last", bus.out_last, e.last);
                        last_acc = e.last;
                        acc_cnt++;
                    end
                end

                outstanding = outstanding + (bus.mem_CEN ? 0 : 1) - (accepted ? 1 : 0);
                active_cur  = active_m;
                done_next   = last_acc;
                if (last_acc)
                    active_m = 1'b0;

                if (bus.start && !active_cur) begin
                    if (bus.length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        active_m    = 1'b1;
                        outstanding = 0;
                        lat_armed   = 1'b1;
                        lat_cnt     = 0;
                        for (int k = 0; k < int'(bus.length); k++) begin
                            int idx;
                            idx = (int'(bus.base_addr) + k) % DEPTH;
                            addr_q.push_back(idx);
                            exp_q.push_back('{data: mem[idx], last: (k == int'(bus.length) - 1)});
                        end
                    end
                end
                done_exp = done_next;

                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, b, l;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = DATA_W'(i + 100);
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();

        // Basic drain, then wrap-around past the top of the buffer.
        ready_mode = 0;
        do_start(5, 4);
        wait_idle(50);
        do_start(1022, 4);
        wait_idle(50);

        // Stalls with the 1,0,0,1 back-pressure pattern.
        ready_mode = 1;
        pat_idx = 0;
        do_start(37, 8);
        wait_idle(100);

        // Zero-length start.
        ready_mode = 0;
        do_start(12, 0);
        wait_idle(10);

        // Reset in the middle of a 10-word drain after 3 words.
        ready_mode = 1;
        acc_cnt = 0;
        do_start(100, 10);
        n = 0;
        while (acc_cnt < 3 && n < 100) begin
            tick();
            n++;
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ready_mode = 0;
        do_start(0, 2);
        wait_idle(50);

        // A second start during a drain must be ignored.
        ready_mode = 2;
        do_start(200, 12);
        repeat (4) tick();
        do_start(600, 3);
        wait_idle(200);

        // New start issued in the very cycle done is high.
        ready_mode = 0;
        do_start(300, 5);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        do_start(310, 3);
        wait_idle(50);

        // Randomised transfers over fresh buffer contents.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] = $urandom;
            ready_mode = $urandom_range(0, 2);
            b = $urandom_range(0, DEPTH - 1);
            l = (t == 10) ? DEPTH : $urandom_range(0, 40);
            do_start(b, l);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) tick();
                do_start($urandom_range(0, DEPTH - 1), $urandom_range(0, 20));
            end
            wait_idle(4 * l + 200);
        end

        repeat (4) tick();
        chk("leftover_words", 64'(exp_q.size()), 64'd0);
        chk("leftover_reads", 64'(addr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
